mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares one single-port unified instruction/data memory between the CPU fetch port and the CPU load/store port. It sits between `cpu` and a unified memory that replaces separate instruction and data memories, and is instantiated in `top`. Each port gets a request/grant/response handshake. Memory read latency is a fixed number of cycles, so the CPU stalls on the grant and response signals instead of assuming single-cycle memory.

## Interface
Parameters:
- `MEM_LAT`, default 1: cycles from the memory request cycle to valid `m_rdata`. Must be ≥ 1.
- `STARVE_LIMIT`, default 4: number of consecutive contested data-port wins before the fetch port is forced through. Used only with the fairness feature.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `i_req`  in  1  fetch request
- `i_addr`  in  32  fetch word address
- `i_gnt`  out  1  fetch accepted, one-cycle pulse
- `i_rvalid`  out  1  fetch data valid, one-cycle pulse
- `i_rdata`  out  32  fetch data
- `d_req`  in  1  data-port request
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  32  data address
- `d_wdata`  in  32  write data
- `d_gnt`  out  1  data-port request accepted, one-cycle pulse
- `d_rvalid`  out  1  data-port completion, one-cycle pulse; asserted for reads and writes
- `d_rdata`  out  32  read data; 0 on write completion
- `m_req`  out  1  memory access strobe
- `m_we`  out  1  memory write enable
- `m_addr`  out  32  memory address
- `m_wdata`  out  32  memory write data
- `m_rdata`  in  32  memory read data

## Operation
- At most one transaction is outstanding. State is `IDLE` or `BUSY`, plus `owner` (NONE/I/D) and a latency counter `cnt`.
- **Grant cycle:**
  - `m_req` = 1 and the winner's `gnt` = 1, both combinational.
  - `m_addr`/`m_we`/`m_wdata` come from the winner. Fetch grants drive `m_we` = 0 and `m_wdata` = 0.
  - On the clock edge, state goes to `BUSY`, `cnt` ← 1 and `owner` ← winner.
- **Arbitration when both ports request:** the data port wins by default. See Configuration for the exception.
- **`BUSY`:**
  - While `cnt` < `MEM_LAT`, `cnt` increments.
  - When `cnt` == `MEM_LAT`, the owner's `rvalid` = 1 and its `rdata` = `m_rdata`. The other port's `rdata` reads 0.
  - In that same completion cycle a new grant may issue; state stays `BUSY` with `cnt` ← 1. With no request pending, state goes to `IDLE` and `owner` ← NONE.
- **Requester rules:**
  - Hold `req` and the address/data fields stable until `gnt`.
  - Drop `req` in the cycle after `gnt`.
  - Do not re-assert `req` before its own `rvalid`, except in the `rvalid` cycle itself.
  - Violating any of these is an error, flagged by a simulation-only assertion.
- **Outputs while idle:**
  - `gnt`, `rvalid` and `m_req` are 0.
  - `m_addr`, `m_we`, `m_wdata`, `i_rdata` and `d_rdata` are 0.

## Timing
- **Reset:**
  - Asynchronous. Forces `IDLE`, `owner` = NONE, `cnt` = 0 and the fairness counter to 0.
  - Every output is 0 while reset is asserted.
  - A transaction in flight when reset is asserted is dropped; no `rvalid` follows after reset release.
- **Latency:** a grant at cycle T gives `rvalid` at T+`MEM_LAT`.
- **Throughput:** one transaction per `MEM_LAT` cycles under back-to-back requests.
- **Same-cycle request and completion:** a request that arrives in a completion cycle is granted in that cycle, with no bubble.
- **Combinational paths:** `gnt` depends combinationally on `req`. No combinational path from `m_rdata` to any `gnt`.

## Configuration
- Macro `MEM_ARB_FAIRNESS_EN`.
- **Defined:**
  - A starvation counter increments on each data-port grant made while `i_req` = 1. It saturates at `STARVE_LIMIT`.
  - When the counter equals `STARVE_LIMIT`, the next contested grant goes to the fetch port.
  - The counter clears to 0 on any fetch-port grant.
- **Undefined:** strict data-port priority. The counter is not instantiated and `STARVE_LIMIT` is ignored.

## Structure
- Package `mem_arb_pkg` holds:
  - `owner_e` (OWN_NONE, OWN_I, OWN_D)
  - `state_e` (ST_IDLE, ST_BUSY)
  - `localparam` `XLEN` = 32
- Sub-module `mem_arb_fair` holds the starvation counter and the priority decision. It is compiled only under `MEM_ARB_FAIRNESS_EN`.
- Latency counter width is `$clog2(MEM_LAT+1)`.

## Test plan
- **Single fetch, `MEM_LAT`=1:**
  - Stimulus: `i_req`=1, `i_addr`=0x10 at cycle 0, with memory returning 0x00500113.
  - Response: `i_gnt` and `m_req` high in cycle 0 with `m_addr`=0x10; `i_rvalid`=1 in cycle 1 with `i_rdata`=0x00500113.
- **Contention:**
  - Stimulus: `i_req` and `d_req` both high, `d_we`=1, `d_addr`=0x64, `d_wdata`=0x19.
  - Response: `d_gnt` first, memory write to 0x64 with value 0x19; `d_rvalid` with `d_rdata`=0; `i_gnt` in the same cycle as `d_rvalid`.
- **`MEM_LAT`=3 back-to-back reads:**
  - Stimulus: two back-to-back data-port reads.
  - Response: grants at cycles 0 and 3; `rvalid` at cycles 3 and 6.
- **Fairness:**
  - Stimulus: `MEM_ARB_FAIRNESS_EN` defined, `STARVE_LIMIT`=4, `i_req` held high, continuous data-port requests.
  - Response: exactly 4 data-port grants, then 1 fetch grant, repeating.
  - Without the macro: no fetch grant while `d_req` stays high.
- **Reset mid-flight:**
  - Stimulus: `MEM_LAT`=3; assert reset at cycle 1 after a grant at cycle 0.
  - Response: all outputs 0 immediately; no `rvalid` after release; the first request after release gets a grant in the same cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

endpackage

// File: rtl/mem_arb_fair.sv
// Starvation counter and fetch/data priority decision; built only with MEM_ARB_FAIRNESS_EN.
`ifdef MEM_ARB_FAIRNESS_EN
module mem_arb_fair #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_free,
  input  logic i_fetch_req,
  input  logic i_data_req,
  output logic o_fetch_win,
  output logic o_data_win
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] r_starve;
  logic          w_force;

  assign w_force     = (r_starve == SW'(STARVE_LIMIT));
  assign o_fetch_win = i_free && i_fetch_req && (!i_data_req || w_force);
  assign o_data_win  = i_free && i_data_req && !(i_fetch_req && w_force);

  // Only contested data wins count toward starvation.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_starve <= '0;
    end else if (o_fetch_win) begin
      r_starve <= '0;
    end else if (o_data_win && i_fetch_req && !w_force) begin
      r_starve <= r_starve + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter for a single-port unified memory with fixed read latency.
// Optional fetch-starvation fairness is enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic [XLEN-1:0] m_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be >= 1");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("mem_arbiter: STARVE_LIMIT must be >= 1");
  end

  state_e        r_state, w_state_nxt;
  owner_e        r_owner, w_owner_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_we, w_we_nxt;
  logic          w_done, w_free, w_i_win, w_d_win;

  assign w_done = (r_state == ST_BUSY) && (r_cnt == CW'(MEM_LAT));
  // Reset gating keeps every output low while reset is held, even with requests present.
  assign w_free = !reset && ((r_state == ST_IDLE) || w_done);

`ifdef MEM_ARB_FAIRNESS_EN
  mem_arb_fair #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_fair (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_free     (w_free),
    .i_fetch_req(i_req),
    .i_data_req (d_req),
    .o_fetch_win(w_i_win),
    .o_data_win (w_d_win)
  );
`else
  assign w_i_win = w_free && i_req && !d_req;
  assign w_d_win = w_free && d_req;
`endif

  assign i_gnt    = w_i_win;
  assign d_gnt    = w_d_win;
  assign m_req    = w_i_win || w_d_win;
  assign m_we     = w_d_win && d_we;
  assign m_addr   = w_d_win ? d_addr : (w_i_win ? i_addr : '0);
  assign m_wdata  = w_d_win ? d_wdata : '0;

  assign i_rvalid = w_done && (r_owner == OWN_I);
  assign d_rvalid = w_done && (r_owner == OWN_D);
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = (d_rvalid && !r_we) ? m_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_NONE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = r_we;
    if (w_i_win || w_d_win) begin
      w_state_nxt = ST_BUSY;
      w_owner_nxt = w_d_win ? OWN_D : OWN_I;
      w_cnt_nxt   = CW'(1);
      w_we_nxt    = w_d_win && d_we;
    end else if (w_done) begin
      w_state_nxt = ST_IDLE;
      w_owner_nxt = OWN_NONE;
      w_cnt_nxt   = '0;
      w_we_nxt    = 1'b0;
    end else if (r_state == ST_BUSY) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Requester protocol: hold fields until granted, stay quiet until own rvalid.
  a_i_hold : assert property (@(posedge clk) disable iff (reset)
    (i_req && !i_gnt) |=> (i_req && $stable(i_addr)));
  a_d_hold : assert property (@(posedge clk) disable iff (reset)
    (d_req && !d_gnt) |=> (d_req && $stable({d_we, d_addr, d_wdata})));
  a_i_wait : assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_BUSY && r_owner == OWN_I && i_req) |-> i_rvalid);
  a_d_wait : assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_BUSY && r_owner == OWN_D && d_req) |-> d_rvalid);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios on MEM_LAT=1 and MEM_LAT=3 instances
// plus randomized traffic checked against a cycle-numbered transaction model.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  typedef struct packed {
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
  } out_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic        use3;

  int checks = 0;
  int errors = 0;

  logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_m_req, a_m_we;
  logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata;
  logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_m_req, b_m_we;
  logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
  logic        a_i_req, a_d_req, b_i_req, b_d_req;
  out_t        o;

  assign a_i_req = i_req && !use3;
  assign a_d_req = d_req && !use3;
  assign b_i_req = i_req && use3;
  assign b_d_req = d_req && use3;

  assign o = use3 ?
    {b_i_gnt, b_i_rvalid, b_i_rdata, b_d_gnt, b_d_rvalid, b_d_rdata, b_m_req, b_m_we, b_m_addr, b_m_wdata} :
    {a_i_gnt, a_i_rvalid, a_i_rdata, a_d_gnt, a_d_rvalid, a_d_rdata, a_m_req, a_m_we, a_m_addr, a_m_wdata};

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(STARVE_LIMIT)) u_lat1 (
    .clk(clk), .reset(reset),
    .i_req(a_i_req), .i_addr(i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .m_req(a_m_req), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_rdata(m_rdata)
  );

  mem_arbiter #(.MEM_LAT(3), .STARVE_LIMIT(STARVE_LIMIT)) u_lat3 (
    .clk(clk), .reset(reset),
    .i_req(b_i_req), .i_addr(i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .m_req(b_m_req), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(m_rdata)
  );

  task automatic pulse_reset(input logic sel3);
    @(negedge clk);
    i_req = 1'b0;
    d_req = 1'b0;
    reset = 1'b1;
    use3  = sel3;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    out_t e;
    e = '0;
    i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h88; d_wdata = 32'h1234; m_rdata = 32'hffff_ffff;
    for (int s = 0; s < 2; s++) begin
      use3 = s[0];
      #2;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_outputs lat_sel=%0d: got %h expected %h", s, o, e);
      end
    end
    pulse_reset(1'b0);
    #1;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", o, e);
    end
  endtask

  task automatic test_single_fetch();
    out_t e;
    pulse_reset(1'b0);
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h10; m_rdata = 32'h0;
    #1;
    e = '0; e.i_gnt = 1'b1; e.m_req = 1'b1; e.m_addr = 32'h10;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL single_fetch_grant: got %h expected %h", o, e);
    end
    @(negedge clk);
    i_req = 1'b0; m_rdata = 32'h0050_0113;
    #1;
    e = '0; e.i_rvalid = 1'b1; e.i_rdata = 32'h0050_0113;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL single_fetch_rvalid: got %h expected %h", o, e);
    end
    @(negedge clk);
    m_rdata = 32'h1234_5678;
    #1;
    e = '0;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL single_fetch_idle: got %h expected %h", o, e);
    end
  endtask

  task automatic test_contention();
    out_t e;
    pulse_reset(1'b0);
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h64; d_wdata = 32'h19;
    #1;
    e = '0; e.d_gnt = 1'b1; e.m_req = 1'b1; e.m_we = 1'b1; e.m_addr = 32'h64; e.m_wdata = 32'h19;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL contention_write_grant: got %h expected %h", o, e);
    end
    @(negedge clk);
    d_req = 1'b0; m_rdata = 32'hdead_beef;
    #1;
    e = '0; e.d_rvalid = 1'b1; e.i_gnt = 1'b1; e.m_req = 1'b1; e.m_addr = 32'h20;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL contention_wdone_fetch_grant: got %h expected %h", o, e);
    end
    @(negedge clk);
    i_req = 1'b0; m_rdata = 32'hcafe_f00d;
    #1;
    e = '0; e.i_rvalid = 1'b1; e.i_rdata = 32'hcafe_f00d;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL contention_fetch_rvalid: got %h expected %h", o, e);
    end
  endtask

  task automatic test_back_to_back();
    out_t e;
    pulse_reset(1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      m_rdata = $urandom;
      d_req = 1'b0;
      if (c == 0 || c == 3) begin
        d_req = 1'b1; d_we = 1'b0; d_addr = (c == 0) ? 32'h100 : 32'h104; d_wdata = 32'h0;
      end
      #1;
      e = '0;
      if (c == 0 || c == 3) begin
        e.d_gnt = 1'b1; e.m_req = 1'b1; e.m_addr = d_addr;
      end
      if (c == 3 || c == 6) begin
        e.d_rvalid = 1'b1; e.d_rdata = m_rdata;
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back_c%0d: got %h expected %h", c, o, e);
      end
    end
  endtask

  task automatic test_starve();
    out_t e;
    logic fetch_turn, prev_fetch;
    pulse_reset(1'b0);
    prev_fetch = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = 32'h0;
      m_rdata = $urandom;
      #1;
`ifdef MEM_ARB_FAIRNESS_EN
      fetch_turn = ((c % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
`else
      fetch_turn = 1'b0;
`endif
      e = '0;
      e.i_gnt = fetch_turn; e.d_gnt = !fetch_turn; e.m_req = 1'b1;
      e.m_addr = fetch_turn ? 32'h40 : 32'h80;
      if (c > 0) begin
        e.i_rvalid = prev_fetch;  e.i_rdata = prev_fetch ? m_rdata : 32'h0;
        e.d_rvalid = !prev_fetch; e.d_rdata = prev_fetch ? 32'h0 : m_rdata;
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL starve_c%0d: got %h expected %h", c, o, e);
      end
      prev_fetch = fetch_turn;
    end
    pulse_reset(1'b0);
  endtask

  task automatic test_reset_midflight();
    out_t e;
    pulse_reset(1'b1);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0;
    #1;
    e = '0; e.d_gnt = 1'b1; e.m_req = 1'b1; e.m_addr = 32'h200;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL midflight_grant: got %h expected %h", o, e);
    end
    @(negedge clk);
    d_req = 1'b0;
    #1 reset = 1'b1;
    #1;
    e = '0;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL midflight_reset_outputs: got %h expected %h", o, e);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      m_rdata = $urandom;
      #1;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midflight_no_rvalid_k%0d: got %h expected %h", k, o, e);
      end
      @(negedge clk);
    end
    d_req = 1'b1; d_addr = 32'h300;
    #1;
    e = '0; e.d_gnt = 1'b1; e.m_req = 1'b1; e.m_addr = 32'h300;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL midflight_first_grant: got %h expected %h", o, e);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      d_req = 1'b0; m_rdata = $urandom;
      #1;
      e = '0;
      if (k == 3) begin
        e.d_rvalid = 1'b1; e.d_rdata = m_rdata;
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midflight_after_k%0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  // Model: one outstanding transaction completing at an absolute cycle number.
  task automatic test_random(input logic sel3, input int ncyc);
    out_t e;
    int   lat, t, done_cyc, owner;
    logic busy, own_we, i_pend, i_wait, d_pend, d_wait;
    logic exp_done, free, force_i, iw, dw, quiet;
`ifdef MEM_ARB_FAIRNESS_EN
    int starve = 0;
`endif
    lat = sel3 ? 3 : 1;
    pulse_reset(sel3);
    busy = 1'b0; own_we = 1'b0; owner = 0; done_cyc = 0; t = 0;
    i_pend = 1'b0; i_wait = 1'b0; d_pend = 1'b0; d_wait = 1'b0; quiet = 1'b0;
    for (int n = 0; n < ncyc + 60; n++) begin
      @(negedge clk);
      exp_done = busy && (t == done_cyc);
      if (exp_done && owner == 1) i_wait = 1'b0;
      if (exp_done && owner == 2) d_wait = 1'b0;
      if (n >= ncyc && !i_pend && !d_pend && !busy) begin
        i_req = 1'b0; d_req = 1'b0; quiet = 1'b1;
        break;
      end
      if (n < ncyc && !i_pend && !i_wait && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1; i_addr = $urandom;
      end
      if (n < ncyc && !d_pend && !d_wait && $urandom_range(0, 2) != 0) begin
        d_pend = 1'b1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
      i_req = i_pend; d_req = d_pend; m_rdata = $urandom;
      #1;
      free = !busy || exp_done;
      force_i = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
      force_i = (starve == STARVE_LIMIT);
`endif
      iw = free && i_pend && (!d_pend || force_i);
      dw = free && d_pend && !(i_pend && force_i);
      e = '0;
      e.i_gnt = iw; e.d_gnt = dw; e.m_req = iw || dw; e.m_we = dw && d_we;
      e.m_addr = dw ? d_addr : (iw ? i_addr : 32'h0);
      e.m_wdata = dw ? d_wdata : 32'h0;
      e.i_rvalid = exp_done && owner == 1;
      e.i_rdata = e.i_rvalid ? m_rdata : 32'h0;
      e.d_rvalid = exp_done && owner == 2;
      e.d_rdata = (e.d_rvalid && !own_we) ? m_rdata : 32'h0;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random_lat%0d_t%0d: got %h expected %h", lat, t, o, e);
      end
`ifdef MEM_ARB_FAIRNESS_EN
      if (iw) starve = 0;
      else if (dw && i_pend && starve < STARVE_LIMIT) starve++;
`endif
      if (iw || dw) begin
        busy = 1'b1; owner = iw ? 1 : 2; own_we = dw && d_we; done_cyc = t + lat;
      end else if (exp_done) begin
        busy = 1'b0; owner = 0;
      end
      if (iw) begin i_pend = 1'b0; i_wait = 1'b1; end
      if (dw) begin d_pend = 1'b0; d_wait = 1'b1; end
      t++;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL random_lat%0d_drain: got busy=%0d pend=%0d/%0d expected idle", lat, busy, i_pend, d_pend);
    end
  endtask

  initial begin
    reset = 1'b0; use3 = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    #1 reset = 1'b1;
    test_reset();
    test_single_fetch();
    test_contention();
    test_back_to_back();
    test_starve();
    test_reset_midflight();
    test_random(1'b1, 600);
    test_random(1'b0, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
